// File: rtl/alarm_latch_ctrl.sv
// alarm_latch_ctrl: arms and disarms the system, debounces the raw alarm
// flag into a latched alarm, drives a time-limited pulsing siren, and locks
// out disarm attempts after three consecutive wrong codes.
module alarm_latch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 32'd4,
    parameter int unsigned SIREN_CYCLES      = 32'd32,
    parameter int unsigned SIREN_HALF_PERIOD = 32'd2,
    parameter logic [3:0]  DISARM_CODE       = 4'hA,
    parameter int unsigned LOCKOUT_CYCLES    = 32'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       al,
    input  logic       arm,
    input  logic       disarm_req,
    input  logic [3:0] disarm_code,
    output logic [1:0] state,
    output logic       alarm_active,
    output logic       siren,
    output logic       bad_code,
    output logic       locked_out,
    output logic [7:0] event_count
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int unsigned SIR_W = (SIREN_CYCLES < 32'd1) ? 32'd1 : $clog2(SIREN_CYCLES + 32'd1);
    localparam int unsigned PH_W  = $clog2(SIREN_HALF_PERIOD + 32'd1);
    localparam int unsigned LCK_W = (LOCKOUT_CYCLES < 32'd1) ? 32'd1 : $clog2(LOCKOUT_CYCLES + 32'd1);

    // Debounce counter value on the last required high sample.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 32'd1);
    // Siren timer value of the final pulsing ALARM cycle, and its parked value.
    localparam logic [SIR_W-1:0] SIR_LAST = SIR_W'(SIREN_CYCLES - 32'd1);
    localparam logic [SIR_W-1:0] SIR_END  = SIR_W'(SIREN_CYCLES);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SIREN_HALF_PERIOD - 32'd1);
    localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_PENDING  = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    state_t           r_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [SIR_W-1:0] r_sir_tmr;
    logic [PH_W-1:0]  r_sir_phase;
    logic             r_siren;
    logic             r_alarm_active;
    logic             r_bad_code;
    logic [1:0]       r_wrong_cnt;
    logic             r_locked_out;
    logic [LCK_W-1:0] r_lock_tmr;
    logic [7:0]       r_event_count;

    state_t           w_state_nxt;
    logic [DEB_W-1:0] w_deb_nxt;
    logic [SIR_W-1:0] w_sir_tmr_nxt;
    logic [PH_W-1:0]  w_sir_phase_nxt;
    logic             w_siren_nxt;
    logic             w_bad_code_nxt;
    logic [1:0]       w_wrong_nxt;
    logic             w_locked_nxt;
    logic [LCK_W-1:0] w_lock_tmr_nxt;
    logic [7:0]       w_event_nxt;
    logic             w_alarm_entry;
    logic             w_req_live;
    logic             w_valid;
    logic             w_wrong;

    // Disarm requests only count outside DISARMED and outside a lockout.
    assign w_req_live    = disarm_req && !r_locked_out && (r_state != ST_DISARMED);
    assign w_valid       = w_req_live && (disarm_code == DISARM_CODE);
    assign w_wrong       = w_req_live && (disarm_code != DISARM_CODE);
    assign w_alarm_entry = (w_state_nxt == ST_ALARM) && (r_state != ST_ALARM);

    // Next-state logic: valid disarm wins over al, al wins over arm.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        case (r_state)
            ST_DISARMED: begin
                w_deb_nxt = {DEB_W{1'b0}};
                if (arm) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_DISARMED;
                end
            end
            ST_ARMED: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                    w_deb_nxt   = {DEB_W{1'b0}};
                end else if (al) begin
                    w_state_nxt = ST_PENDING;
                    w_deb_nxt   = DEB_W'(32'd1);
                end else begin
                    w_state_nxt = ST_ARMED;
                    w_deb_nxt   = {DEB_W{1'b0}};
                end
            end
            ST_PENDING: begin
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                    w_deb_nxt   = {DEB_W{1'b0}};
                end else if (!al) begin
                    w_state_nxt = ST_ARMED;
                    w_deb_nxt   = {DEB_W{1'b0}};
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = ST_ALARM;
                    w_deb_nxt   = {DEB_W{1'b0}};
                end else begin
                    w_state_nxt = ST_PENDING;
                    w_deb_nxt   = r_deb_cnt + DEB_W'(32'd1);
                end
            end
            ST_ALARM: begin
                w_deb_nxt = {DEB_W{1'b0}};
                if (w_valid) begin
                    w_state_nxt = ST_DISARMED;
                end else begin
                    w_state_nxt = ST_ALARM;
                end
            end
            default: begin
                w_state_nxt = ST_DISARMED;
                w_deb_nxt   = {DEB_W{1'b0}};
            end
        endcase
    end

    // Siren timing: restart high on ALARM entry, toggle each half period, then park low.
    always_comb begin
        w_sir_tmr_nxt   = r_sir_tmr;
        w_sir_phase_nxt = r_sir_phase;
        w_siren_nxt     = r_siren;
        if (w_state_nxt != ST_ALARM) begin
            w_sir_tmr_nxt   = {SIR_W{1'b0}};
            w_sir_phase_nxt = {PH_W{1'b0}};
            w_siren_nxt     = 1'b0;
        end else if (w_alarm_entry) begin
            w_sir_tmr_nxt   = {SIR_W{1'b0}};
            w_sir_phase_nxt = {PH_W{1'b0}};
            w_siren_nxt     = 1'b1;
        end else if (r_sir_tmr < SIR_LAST) begin
            w_sir_tmr_nxt = r_sir_tmr + SIR_W'(32'd1);
            if (r_sir_phase >= PH_LAST) begin
                w_sir_phase_nxt = {PH_W{1'b0}};
                w_siren_nxt     = ~r_siren;
            end else begin
                w_sir_phase_nxt = r_sir_phase + PH_W'(32'd1);
                w_siren_nxt     = r_siren;
            end
        end else begin
            w_sir_tmr_nxt   = SIR_END;
            w_sir_phase_nxt = {PH_W{1'b0}};
            w_siren_nxt     = 1'b0;
        end
    end

    // Wrong-code counting, lockout timer and saturating ALARM entry count.
    always_comb begin
        w_bad_code_nxt = 1'b0;
        w_wrong_nxt    = r_wrong_cnt;
        w_locked_nxt   = r_locked_out;
        w_lock_tmr_nxt = r_lock_tmr;
        w_event_nxt    = r_event_count;
        if (r_locked_out) begin
            if (r_lock_tmr <= LCK_W'(32'd1)) begin
                w_lock_tmr_nxt = {LCK_W{1'b0}};
                w_locked_nxt   = 1'b0;
            end else begin
                w_lock_tmr_nxt = r_lock_tmr - LCK_W'(32'd1);
                w_locked_nxt   = 1'b1;
            end
        end else if (w_wrong) begin
            w_bad_code_nxt = 1'b1;
            if (r_wrong_cnt == 2'd2) begin
                w_wrong_nxt    = 2'd0;
                w_locked_nxt   = 1'b1;
                w_lock_tmr_nxt = LCK_LOAD;
            end else begin
                w_wrong_nxt = r_wrong_cnt + 2'd1;
            end
        end else if (w_valid) begin
            w_wrong_nxt = 2'd0;
        end else begin
            w_wrong_nxt = r_wrong_cnt;
        end
        if (w_alarm_entry && (r_event_count != 8'hFF)) begin
            w_event_nxt = r_event_count + 8'd1;
        end else begin
            w_event_nxt = r_event_count;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_DISARMED;
            r_deb_cnt      <= {DEB_W{1'b0}};
            r_sir_tmr      <= {SIR_W{1'b0}};
            r_sir_phase    <= {PH_W{1'b0}};
            r_siren        <= 1'b0;
            r_alarm_active <= 1'b0;
            r_bad_code     <= 1'b0;
            r_wrong_cnt    <= 2'd0;
            r_locked_out   <= 1'b0;
            r_lock_tmr     <= {LCK_W{1'b0}};
            r_event_count  <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_deb_cnt      <= w_deb_nxt;
            r_sir_tmr      <= w_sir_tmr_nxt;
            r_sir_phase    <= w_sir_phase_nxt;
            r_siren        <= w_siren_nxt;
            r_alarm_active <= (w_state_nxt == ST_ALARM);
            r_bad_code     <= w_bad_code_nxt;
            r_wrong_cnt    <= w_wrong_nxt;
            r_locked_out   <= w_locked_nxt;
            r_lock_tmr     <= w_lock_tmr_nxt;
            r_event_count  <= w_event_nxt;
        end
    end

    assign state        = r_state;
    assign alarm_active = r_alarm_active;
    assign siren        = r_siren;
    assign bad_code     = r_bad_code;
    assign locked_out   = r_locked_out;
    assign event_count  = r_event_count;

endmodule
